// File: rtl/score_event_encoder.sv
// Queues gold/diamond/monster event pulses per type and serializes them as BCD "add hundreds" valid/ready transactions.
// Optional SCORE_FRAME_PACE_EN: a frame token set by startOfFrame limits issue to one transaction per frame.
module score_event_encoder #(
  parameter int GOLD_HUNDREDS    = 2,
  parameter int DIAMOND_HUNDREDS = 1,
  parameter int MONSTER_HUNDREDS = 5,
  parameter int CNT_W            = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       game_restart,
  input  logic       player_eat_gold,
  input  logic       player_eat_dimond,
  input  logic       monster_killed,
  input  logic       add_ready,
  output logic       add_valid,
  output logic [3:0] add_hundreds,
  output logic [1:0] add_kind,
  output logic       pending,
  output logic       overflow_drop
);

  localparam logic [3:0] GOLD_H = (GOLD_HUNDREDS    > 9) ? 4'd9 : 4'(GOLD_HUNDREDS);
  localparam logic [3:0] DIA_H  = (DIAMOND_HUNDREDS > 9) ? 4'd9 : 4'(DIAMOND_HUNDREDS);
  localparam logic [3:0] MON_H  = (MONSTER_HUNDREDS > 9) ? 4'd9 : 4'(MONSTER_HUNDREDS);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state_q, state_d;
  // Index matches add_kind: 0 gold, 1 diamond, 2 monster.
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       ev, load, drop, nonzero;
  logic [3:0]       sel_hundreds;
  logic [1:0]       sel_kind;
  logic             frame_ok;

  assign ev = {monster_killed, player_eat_dimond, player_eat_gold};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nonzero[i] = (cnt[i] != '0);
      drop[i]    = ev[i] & ~load[i] & (cnt[i] == '1);
    end
  end

`ifdef SCORE_FRAME_PACE_EN
  logic token_q;

  // startOfFrame wins over a same-cycle load so the next frame is not missed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)            token_q <= 1'b0;
    else if (game_restart)  token_q <= 1'b0;
    else if (startOfFrame)  token_q <= 1'b1;
    else if (|load)         token_q <= 1'b0;
  end

  assign frame_ok = token_q;
`else
  // Unpaced: always ready to issue; startOfFrame has no effect.
  assign frame_ok = 1'b1 | startOfFrame;
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (game_restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (|load)    state_d = OFFER;
        OFFER:   if (add_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/selection logic: fixed priority monster > gold > diamond
  always_comb begin
    load         = 3'b000;
    sel_kind     = 2'd0;
    sel_hundreds = 4'd0;
    if (state_q == IDLE && !game_restart && frame_ok) begin
      if (nonzero[2]) begin
        load[2]      = 1'b1;
        sel_kind     = 2'd2;
        sel_hundreds = MON_H;
      end else if (nonzero[0]) begin
        load[0]      = 1'b1;
        sel_kind     = 2'd0;
        sel_hundreds = GOLD_H;
      end else if (nonzero[1]) begin
        load[1]      = 1'b1;
        sel_kind     = 2'd1;
        sel_hundreds = DIA_H;
      end
    end
  end

  assign add_valid = (state_q == OFFER);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      add_hundreds <= 4'd0;
      add_kind     <= 2'd0;
    end else if (|load) begin
      add_hundreds <= sel_hundreds;
      add_kind     <= sel_kind;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (game_restart) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ev[i] && !load[i] && !drop[i]) cnt[i] <= cnt[i] + CNT_W'(1);
        else if (load[i] && !ev[i])        cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending       <= 1'b0;
      overflow_drop <= 1'b0;
    end else if (game_restart) begin
      pending       <= 1'b0;
      overflow_drop <= 1'b0;
    end else begin
      pending       <= |nonzero;
      overflow_drop <= overflow_drop | (|drop);
    end
  end

endmodule
